muldiv_iter: RTL

- Iterative RV M-extension multiply/divide unit. It replaces the stub multiply/divide unit in the EX stage of the 5-stage core.
- Accepts one operation at a time through a start/ready handshake. Returns a registered result with a one-cycle valid pulse and a passthrough destination tag.
- Produces 1 bit per cycle for both multiply and divide. Divide-by-zero and signed overflow take an optional early-out path.
- Supports pipeline flush so the core can kill an in-flight op on a taken branch or jump.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcode encodings, FSM state type and helpers for the iterative RV M-extension unit.
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV M-extension multiply/divide, one result bit per cycle,
// start/ready handshake, one-cycle valid pulse, flush abort. Rev 1.0
`default_nettype none

module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             ready,
  output logic             valid,
  output logic [XLEN-1:0]  r,
  output logic [TAG_W-1:0] tag_out
);

  localparam int              CW     = $clog2(XLEN);
  localparam logic [CW-1:0]   c_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [2:0]         r_f3;
  logic [TAG_W-1:0]   r_tag;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_opb;
  logic [XLEN-1:0]    r_rem;
  logic               r_valid;
  logic [XLEN-1:0]    r_r;
  logic [TAG_W-1:0]   r_tag_out;

  // Operand conditioning at accept
  logic            w_accept;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_early;
  logic [XLEN-1:0] w_early_res;

  assign ready    = ~rst & (r_state != CALC);
  assign w_accept = start & ready & ~flush;

  assign w_sa = ((funct3 == MD_MULH) | (funct3 == MD_MULHSU) |
                 (funct3 == MD_DIV)  | (funct3 == MD_REM)) & a[XLEN-1];
  assign w_sb = ((funct3 == MD_MULH) | (funct3 == MD_DIV) |
                 (funct3 == MD_REM)) & b[XLEN-1];

  assign w_mag_a  = w_sa ? (~a + 1'b1) : a;
  assign w_mag_b  = w_sb ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);
  assign w_ovf    = ((funct3 == MD_DIV) | (funct3 == MD_REM)) & (a == c_MIN) & (&b);
  assign w_early  = EARLY_OUT & is_div(funct3) & (w_b_zero | w_ovf);

  // funct3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_early_res = '0;
    if (w_b_zero)
      w_early_res = funct3[1] ? a : '1;
    else
      w_early_res = funct3[1] ? '0 : c_MIN;
  end

  // Shift-add multiply step: conditionally add multiplicand into the high half, shift right
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_add, r_acc[XLEN-1:1]};

  // Restoring divide step; a non-negative trial difference always lies below 2^XLEN
  logic [XLEN:0]   w_sh;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;

  assign w_sh       = {r_rem, r_acc[XLEN-1]};
  assign w_diff     = {1'b0, w_sh} - {2'b00, r_opb};
  assign w_ge       = (w_diff[XLEN+1:XLEN] == 2'b00);
  assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
  assign w_quo_next = {r_acc[XLEN-2:0], w_ge};

  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_res;

  assign w_prod_s = r_neg_q ? (~w_mul_next + 1'b1) : w_mul_next;
  assign w_quo_s  = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_rem_s  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  always_comb begin
    w_res = '0;
    case (r_f3)
      MD_MUL:                      w_res = w_prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_res = w_prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             w_res = w_quo_s;
      default:                     w_res = w_rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_f3      <= '0;
      r_tag     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_rem     <= '0;
      r_valid   <= 1'b0;
      r_r       <= '0;
      r_tag_out <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        CALC: begin
          r_count <= r_count + 1'b1;
          if (is_div(r_f3)) begin
            r_acc[XLEN-1:0] <= w_quo_next;
            r_rem           <= w_rem_next;
          end else begin
            r_acc <= w_mul_next;
          end
          if (r_count == c_LAST) begin
            r_state   <= DONE;
            r_valid   <= 1'b1;
            r_r       <= w_res;
            r_tag_out <= r_tag;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          if (w_accept) begin
            r_f3    <= funct3;
            r_tag   <= tag_in;
            r_count <= '0;
            // Divide-by-zero keeps the all-ones quotient unsigned
            r_neg_q <= (w_sa ^ w_sb) & ~(is_div(funct3) & w_b_zero);
            r_neg_r <= w_sa;
            r_acc   <= {{XLEN{1'b0}}, is_div(funct3) ? w_mag_a : w_mag_b};
            r_opb   <= is_div(funct3) ? w_mag_b : w_mag_a;
            r_rem   <= '0;
            if (w_early) begin
              r_state   <= DONE;
              r_valid   <= 1'b1;
              r_r       <= w_early_res;
              r_tag_out <= tag_in;
            end else begin
              r_state <= CALC;
            end
          end
        end
      endcase
    end
  end

  assign valid   = r_valid;
  assign r       = r_r;
  assign tag_out = r_tag_out;

endmodule

`default_nettype wire
